osc_core: RTL and testbench
===========================

OSC_CORE -- requirements
Module: osc_core

Interface
REQ-001 Parameter PHASE_W, default 24: phase accumulator width; the top 16 bits address the waveform.
REQ-002 Parameter FADE_MAX, default 4096: maximum sample ticks spent in FADE before forcing IDLE.
REQ-003 CLK  in  1  clock; all state changes on its rising edge.
REQ-004 RESET  in  1  reset; synchronous, active-high.
REQ-005 Enable  in  1  block enable; low forces IDLE.
REQ-006 key_on  in  1  note gate from the key/glide path.
REQ-007 sample_tick  in  1  one-cycle audio-rate strobe; any spacing legal, including back-to-back.
REQ-008 freq  in  16  unsigned phase increment, taken directly from the glide stage output.
REQ-009 wave_sel  in  2  00 saw, 01 square, 10 triangle, 11 pulse.
REQ-010 pulse_width  in  8  pulse duty threshold.
REQ-011 sample  out  16  signed two's-complement audio sample.
REQ-012 sample_valid  out  1  one-cycle strobe; sample is valid when high.
REQ-013 sync_out  out  1  one-cycle strobe coincident with sample_valid when that sample's phase update wrapped.

Function
REQ-014 FSM states:
- IDLE: phase held at 0.
- RUN.
- FADE.
REQ-015 Tick processing:
- Pipeline stage 1 (tick cycle T): freq is sampled only at T; if state is RUN/FADE, phase <= phase + zero-extended freq, modulo 2^PHASE_W; carry-out = wrap.
- Stage 2 (T+1): waveform is computed from the updated phase.
- Stage 3 (T+2): sample and sample_valid=1 are registered.
- Latency is exactly 2 cycles; fully pipelined.
REQ-016 A tick in IDLE, or the tick that causes a FADE->IDLE exit, SHALL still produce sample_valid with sample 0x0000 and sync_out 0.
REQ-017 Waveform mapping, with p = phase[PHASE_W-1:PHASE_W-16]:
- saw = {~p[15], p[14:0]}.
- square = 0x7FFF if p[15]=0, else 0x8000.
- triangle: t = {p[14:0],0} when p[15]=0, else ~{p[14:0],0}; output = {~t[15], t[14:0]}.
- pulse = 0x7FFF if p[15:8] < pulse_width, else 0x8000; pulse_width 0 gives a constant 0x8000.
REQ-018 IDLE->RUN when Enable && key_on; phase cleared to 0 on entry.
REQ-019 RUN->FADE when key_on=0; the fade counter is cleared.
REQ-020 FADE behaviour:
- Phase keeps advancing on each tick.
- A tick with wrap=1 -> IDLE.
- The fade counter increments per tick; on reaching FADE_MAX -> IDLE.
- key_on=1 -> RUN, phase not cleared (legato).
REQ-021 Enable=0 in any state -> IDLE on the next edge and phase cleared; this overrides all other transitions.
REQ-022 Simultaneous tick and transition: the tick is processed under the current (pre-transition) state.
REQ-023 wave_sel and pulse_width are sampled in stage 2; a change mid-pipeline affects only later stage-2 computations.
REQ-024 freq=0 in RUN holds the phase constant; the output holds its value; no sync_out is produced.

Reset
REQ-025 RESET high SHALL set:
- state = IDLE,
- phase = 0,
- fade counter = 0,
- sample = 0x0000, sample_valid = 0, sync_out = 0,
- all pipeline valid bits = 0.
REQ-026 RESET overrides Enable, key_on and sample_tick in the same cycle.
REQ-027 Ticks in flight when RESET is asserted SHALL produce no sample_valid, including after RESET deasserts.

Verification
REQ-028 Reset; Enable=1, key_on=1, wave_sel=00, freq=0x0100, then one tick -> sample_valid 2 cycles later, sample=0x8001, sync_out=0.
REQ-029 freq=0xFFFF in RUN, saw -> sync_out=1 on exactly the 257th sample after RUN entry and on no earlier sample.
REQ-030 freq=0x8000, 256 ticks -> p=0x8000; triangle gives 0x7FFF, square gives 0x8000, pulse with pulse_width=0x81 gives 0x7FFF.
REQ-031 key_on dropped with freq=0 -> FADE; FADE_MAX ticks later state=IDLE; all following samples 0x0000.
REQ-032 key_on dropped then re-raised within FADE -> RUN with no phase discontinuity (next saw sample = previous + freq>>8).
REQ-033 Enable=0 mid-RUN -> the next tick's sample is 0x0000; RESET one cycle after a tick -> no sample_valid for that tick.

Source files
------------

// File: rtl/osc_if.sv
// Control and audio-output signals of the oscillator core.
// The master side drives the note/tick controls; the slave side is the oscillator.
interface osc_if;
  logic               Enable;
  logic               key_on;
  logic               sample_tick;
  logic [15:0]        freq;
  logic [1:0]         wave_sel;
  logic [7:0]         pulse_width;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               sync_out;

  modport master (
    output Enable, key_on, sample_tick, freq, wave_sel, pulse_width,
    input  sample, sample_valid, sync_out
  );

  modport slave (
    input  Enable, key_on, sample_tick, freq, wave_sel, pulse_width,
    output sample, sample_valid, sync_out
  );
endinterface

// File: rtl/osc_core.sv
// Phase-accumulator oscillator with IDLE/RUN/FADE gating and a two-cycle
// tick-to-sample pipeline producing saw, square, triangle or pulse samples.
module osc_core #(
  parameter int PHASE_W  = 24,
  parameter int FADE_MAX = 4096
) (
  input logic CLK,
  input logic RESET,
  osc_if.slave bus
);

  localparam int CNT_W = $clog2(FADE_MAX + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FADE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [PHASE_W-1:0] r_phase;
  logic [CNT_W-1:0]   r_fade_cnt;
  logic [CNT_W-1:0]   w_fade_inc;
  logic [PHASE_W:0]   w_sum;
  logic               w_wrap;
  logic               w_active;
  logic               w_fade_exit;

  logic [PHASE_W-1:0] r_phase_p1;
  logic               r_vld_p1;
  logic               r_wrap_p1;
  logic               r_mute_p1;

  logic signed [15:0] r_sample_p2;
  logic               r_vld_p2;
  logic               r_sync_p2;

  function automatic logic signed [15:0] f_wave(
    input logic [15:0] p,
    input logic [1:0]  sel,
    input logic [7:0]  pw
  );
    logic [15:0] t;
    t = p[15] ? ~{p[14:0], 1'b0} : {p[14:0], 1'b0};
    case (sel)
      2'b00:   f_wave = $signed({~p[15], p[14:0]});
      2'b01:   f_wave = p[15] ? 16'sh8000 : 16'sh7FFF;
      2'b10:   f_wave = $signed({~t[15], t[14:0]});
      default: f_wave = (p[15:8] < pw) ? 16'sh7FFF : 16'sh8000;
    endcase
  endfunction

  assign w_sum       = {1'b0, r_phase} + {{(PHASE_W - 15){1'b0}}, bus.freq};
  assign w_wrap      = w_sum[PHASE_W];
  assign w_active    = (r_state == S_RUN) || (r_state == S_FADE);
  assign w_fade_inc  = r_fade_cnt + 1'b1;
  // The exiting tick itself is muted; exit takes priority over a legato re-key.
  assign w_fade_exit = (r_state == S_FADE) && bus.sample_tick &&
                       (w_wrap || (w_fade_inc == CNT_W'(FADE_MAX)));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.key_on) w_state_nxt = S_RUN;
      S_RUN:   if (!bus.key_on) w_state_nxt = S_FADE;
      S_FADE: begin
        if (w_fade_exit)     w_state_nxt = S_IDLE;
        else if (bus.key_on) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!bus.Enable) w_state_nxt = S_IDLE;
  end

  // Stage 1: state, accumulator and tick capture
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_fade_cnt <= '0;
      r_vld_p1   <= 1'b0;
      r_wrap_p1  <= 1'b0;
      r_mute_p1  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == S_IDLE)
        r_phase <= '0;
      else if (bus.sample_tick && w_active)
        r_phase <= w_sum[PHASE_W-1:0];
      if (r_state != S_FADE)
        r_fade_cnt <= '0;
      else if (bus.sample_tick)
        r_fade_cnt <= w_fade_inc;
      r_vld_p1  <= bus.sample_tick;
      r_wrap_p1 <= w_wrap && w_active && !w_fade_exit;
      r_mute_p1 <= !w_active || w_fade_exit;
    end
  end

  // Phase copy for the waveform stage survives an accumulator clear on the same edge.
  always_ff @(posedge CLK) begin
    if (bus.sample_tick)
      r_phase_p1 <= w_active ? w_sum[PHASE_W-1:0] : '0;
  end

  // Stage 2: waveform lookup and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sample_p2 <= '0;
      r_vld_p2    <= 1'b0;
      r_sync_p2   <= 1'b0;
    end else begin
      r_vld_p2  <= r_vld_p1;
      r_sync_p2 <= r_vld_p1 && r_wrap_p1;
      if (r_vld_p1)
        r_sample_p2 <= r_mute_p1 ? 16'sh0000
                     : f_wave(r_phase_p1[PHASE_W-1 -: 16], bus.wave_sel, bus.pulse_width);
    end
  end

  assign bus.sample       = r_sample_p2;
  assign bus.sample_valid = r_vld_p2;
  assign bus.sync_out     = r_sync_p2;

endmodule

// File: tb/tb_osc_core.sv
// Directed bench for osc_core: a phase model queues expected samples per tick,
// and every cycle the outputs are popped and compared against that queue.
module tb_osc_core;

  typedef struct {
    logic [15:0] s;
    logic        sy;
    int          due;
    int          n;
  } exp_t;

  logic  CLK = 1'b0;
  logic  RESET = 1'b1;
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  int    nidx = 0;
  string tname = "reset";
  logic [23:0] m_phase = '0;
  exp_t  exp_q[$];

  osc_if bus();

  osc_core #(.PHASE_W(24), .FADE_MAX(8)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [15:0] ref_wave(input logic [15:0] p, input logic [1:0] sel,
                                           input logic [7:0] pw);
    int pi;
    int v;
    pi = int'(p);
    case (sel)
      2'b00:   v = pi - 32768;
      2'b01:   v = (pi < 32768) ? 32767 : -32768;
      2'b10:   v = (pi < 32768) ? (2 * pi - 32768) : (65535 - 2 * (pi - 32768) - 32768);
      default: v = ((pi / 256) < int'(pw)) ? 32767 : -32768;
    endcase
    return 16'(v);
  endfunction

  task automatic step();
    exp_t e;
    @(negedge CLK);
    if (bus.sample_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_valid[%s] got sample_valid=1 want 0 at cycle %0d", tname, cyc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (bus.sample === e.s) else begin
          failures++;
          $error("FAIL sample[%s#%0d] got %h want %h", tname, e.n, bus.sample, e.s);
        end
        checks++;
        assert (bus.sync_out === e.sy) else begin
          failures++;
          $error("FAIL sync_out[%s#%0d] got %b want %b", tname, e.n, bus.sync_out, e.sy);
        end
        checks++;
        assert (cyc === e.due) else begin
          failures++;
          $error("FAIL latency[%s#%0d] got cycle %0d want cycle %0d", tname, e.n, cyc, e.due);
        end
      end
    end else begin
      checks++;
      assert (bus.sync_out === 1'b0) else begin
        failures++;
        $error("FAIL stray_sync[%s] got %b want 0", tname, bus.sync_out);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // mode 0: tick while IDLE; 1: normal tick; 2: tick that ends FADE.
  task automatic tick(input int mode);
    exp_t e;
    logic [24:0] s;
    e.s  = 16'h0000;
    e.sy = 1'b0;
    if (mode != 0) begin
      s = {1'b0, m_phase} + 25'(bus.freq);
      m_phase = s[23:0];
      if (mode == 1) begin
        e.s  = ref_wave(m_phase[23:8], bus.wave_sel, bus.pulse_width);
        e.sy = s[24];
      end else begin
        m_phase = '0;
      end
    end
    e.due = cyc + 2;
    e.n   = nidx;
    nidx++;
    exp_q.push_back(e);
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    checks++;
    assert (bus.sample === 16'h0000 && bus.sample_valid === 1'b0 && bus.sync_out === 1'b0)
    else begin
      failures++;
      $error("FAIL %s got sample=%h valid=%b sync=%b want 0000/0/0",
             tag, bus.sample, bus.sample_valid, bus.sync_out);
    end
  endtask

  initial begin
    bus.Enable      = 1'b0;
    bus.key_on      = 1'b0;
    bus.sample_tick = 1'b0;
    bus.freq        = 16'h0000;
    bus.wave_sel    = 2'b00;
    bus.pulse_width = 8'h00;
    idle(3);
    check_quiet("reset_state");
    RESET = 1'b0;

    tname = "first_tick";
    bus.Enable = 1'b1; bus.key_on = 1'b1; bus.freq = 16'h0100;
    step();
    tick(1);
    idle(3);

    tname = "wrap_257";
    bus.Enable = 1'b0; step(); m_phase = '0;
    bus.Enable = 1'b1; step();
    bus.freq = 16'hFFFF;
    repeat (257) tick(1);
    idle(3);

    tname = "idle_tick";
    bus.Enable = 1'b0; step(); m_phase = '0;
    tick(0);
    idle(3);

    tname = "half_phase";
    bus.Enable = 1'b1; step();
    bus.freq = 16'h8000;
    repeat (256) tick(1);
    bus.freq = 16'h0000;
    idle(3);
    bus.wave_sel = 2'b01; tick(1); idle(3);
    bus.wave_sel = 2'b10; tick(1); idle(3);
    bus.wave_sel = 2'b11; bus.pulse_width = 8'h81; tick(1); idle(3);
    bus.pulse_width = 8'h80; tick(1); idle(3);
    bus.pulse_width = 8'h00; tick(1); idle(3);

    tname = "fade_timeout";
    bus.wave_sel = 2'b01;
    bus.key_on = 1'b0; step();
    repeat (7) tick(1);
    tick(2);
    tick(0); tick(0);
    idle(3);

    tname = "legato";
    bus.key_on = 1'b1; step();
    bus.wave_sel = 2'b00; bus.freq = 16'h0300;
    repeat (4) tick(1);
    bus.key_on = 1'b0; step();
    repeat (2) tick(1);
    bus.key_on = 1'b1; step();
    repeat (2) tick(1);
    idle(3);

    tname = "fade_wrap";
    bus.Enable = 1'b0; step(); m_phase = '0;
    bus.Enable = 1'b1; step();
    bus.freq = 16'hFFFF;
    repeat (255) tick(1);
    bus.key_on = 1'b0; step();
    tick(1);
    tick(2);
    tick(0);
    bus.key_on = 1'b1; step();
    idle(3);

    tname = "enable_drop";
    bus.freq = 16'h0100;
    repeat (2) tick(1);
    bus.Enable = 1'b0; step(); m_phase = '0;
    tick(0);
    bus.Enable = 1'b1; step();
    idle(3);

    tname = "reset_inflight";
    bus.sample_tick = 1'b1; step(); bus.sample_tick = 1'b0;
    RESET = 1'b1;
    idle(3);
    check_quiet("reset_mid_pipe");
    RESET = 1'b0;
    idle(4);
    bus.sample_tick = 1'b1; RESET = 1'b1; step(); bus.sample_tick = 1'b0;
    idle(3);
    check_quiet("reset_with_tick");
    RESET = 1'b0;
    idle(4);

    tname = "drain";
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL drain got %0d pending samples want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
